// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: maps N_RD round-robin readers and N_WR round-robin writers onto a 2R1W regfile.
// Defining RFARB_PERF_CNT_EN adds saturating read-grant and hazard-stall counters.
module regfile_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int N_RD = 4,
  parameter int N_WR = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic [N_RD-1:0] rd_req,
  output logic [N_RD-1:0] rd_gnt,
  input  logic [5*N_RD-1:0] rd_addr,
  output logic [N_RD-1:0] rd_rvalid,
  output logic [DATA_WIDTH*N_RD-1:0] rd_rdata,
  input  logic [N_WR-1:0] wr_req,
  output logic [N_WR-1:0] wr_gnt,
  input  logic [5*N_WR-1:0] wr_addr,
  input  logic [DATA_WIDTH*N_WR-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] din,
  output logic [4:0] wad1,
  output logic wen1,
  output logic [4:0] rad1,
  output logic ren1,
  output logic [4:0] rad2,
  output logic ren2,
  input  logic [DATA_WIDTH-1:0] dout1,
  input  logic [DATA_WIDTH-1:0] dout2,
  input  logic collision,
  input  logic flush,
  output logic flush_done,
  output logic err_collision,
  output logic [15:0] perf_rd_cnt,
  output logic [15:0] perf_stall_cnt
);
  localparam int RP = N_RD > 1 ? $clog2(N_RD) : 1;
  localparam int WP = N_WR > 1 ? $clog2(N_WR) : 1;
  localparam logic [1:0] S_RUN = 2'd0, S_DRAIN = 2'd1, S_DONE = 2'd2;
  logic [1:0] r_state;
  logic [RP-1:0] r_rd_ptr, r_own1, r_own2;
  logic [WP-1:0] r_wr_ptr;
  logic r_v1, r_v2, r_err;
  logic w_active;
  logic [4:0] w_raddr [N_RD];
  logic [4:0] w_waddr [N_WR];
  logic [DATA_WIDTH-1:0] w_wdata [N_WR];
  logic [N_RD-1:0] w_hit, w_elig;
  logic [RP-1:0] w_rs1, w_rs2, w_rlast;
  logic [WP-1:0] w_ws;
  logic [RP:0] w_ri;
  logic [WP:0] w_wi;
  genvar i, j;
  assign w_active = r_state == S_RUN && !flush;
  for (i = 0; i < N_RD; i++) begin : g_rd
    assign w_raddr[i] = rd_addr[5*i +: 5];
    assign w_hit[i] = wen1 && w_raddr[i] == wad1;
    assign rd_rvalid[i] = (r_v1 && r_own1 == RP'(i)) || (r_v2 && r_own2 == RP'(i));
    assign rd_rdata[DATA_WIDTH*i +: DATA_WIDTH] = r_v1 && r_own1 == RP'(i) ? dout1 :
                                                  r_v2 && r_own2 == RP'(i) ? dout2 : '0;
  end
  for (j = 0; j < N_WR; j++) begin : g_wr
    assign w_waddr[j] = wr_addr[5*j +: 5];
    assign w_wdata[j] = wr_data[DATA_WIDTH*j +: DATA_WIDTH];
  end
  always_comb begin
    wen1 = 1'b0;
    w_ws = '0;
    w_wi = '0;
    for (int k = 0; k < N_WR; k++) begin
      w_wi = {1'b0, r_wr_ptr} + (WP+1)'(k);
      if (w_wi >= (WP+1)'(N_WR)) w_wi = w_wi - (WP+1)'(N_WR);
      if (!wen1 && w_active && wr_req[w_wi[WP-1:0]]) begin
        wen1 = 1'b1;
        w_ws = w_wi[WP-1:0];
      end
    end
  end
  assign wr_gnt = N_WR'(wen1) << w_ws;
  assign wad1 = wen1 ? w_waddr[w_ws] : '0;
  assign din = wen1 ? w_wdata[w_ws] : '0;
  // a read hitting this cycle's write address loses and retries, so it sees the new data
  assign w_elig = rd_req & ~w_hit & {N_RD{w_active}};
  always_comb begin
    ren1 = 1'b0;
    ren2 = 1'b0;
    w_rs1 = '0;
    w_rs2 = '0;
    w_ri = '0;
    for (int k = 0; k < N_RD; k++) begin
      w_ri = {1'b0, r_rd_ptr} + (RP+1)'(k);
      if (w_ri >= (RP+1)'(N_RD)) w_ri = w_ri - (RP+1)'(N_RD);
      if (w_elig[w_ri[RP-1:0]]) begin
        if (!ren1) begin
          ren1 = 1'b1;
          w_rs1 = w_ri[RP-1:0];
        end else if (!ren2) begin
          ren2 = 1'b1;
          w_rs2 = w_ri[RP-1:0];
        end
      end
    end
  end
  assign rd_gnt = (N_RD'(ren1) << w_rs1) | (N_RD'(ren2) << w_rs2);
  assign rad1 = ren1 ? w_raddr[w_rs1] : '0;
  assign rad2 = ren2 ? w_raddr[w_rs2] : '0;
  assign w_rlast = ren2 ? w_rs2 : w_rs1;
  assign flush_done = r_state == S_DONE;
  assign err_collision = r_err;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_RUN;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_own1 <= '0;
      r_own2 <= '0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= r_state == S_RUN ? (flush ? S_DRAIN : S_RUN) :
                 r_state == S_DRAIN ? (r_v1 || r_v2 ? S_DRAIN : S_DONE) :
                 (flush ? S_DONE : S_RUN);
      if (wen1) r_wr_ptr <= w_ws == WP'(N_WR-1) ? '0 : w_ws + WP'(1);
      if (ren1) r_rd_ptr <= w_rlast == RP'(N_RD-1) ? '0 : w_rlast + RP'(1);
      r_v1 <= ren1;
      r_v2 <= ren2;
      r_own1 <= w_rs1;
      r_own2 <= w_rs2;
      r_err <= r_err | collision;
    end
  end
`ifdef RFARB_PERF_CNT_EN
  logic [15:0] r_rd_cnt, r_stall_cnt;
  logic [16:0] w_rd_sum;
  assign w_rd_sum = {1'b0, r_rd_cnt} + 17'(ren1) + 17'(ren2);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_rd_cnt <= w_rd_sum[16] ? 16'hFFFF : w_rd_sum[15:0];
      if (|(rd_req & w_hit) && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
  assign perf_rd_cnt = r_rd_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`else
  assign perf_rd_cnt = '0;
  assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: directed scenarios plus random traffic against a queue-free behavioural model.
module tb_regfile_port_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;
  logic [3:0] rd_req, rd_gnt, rd_rvalid;
  logic [19:0] rd_addr;
  logic [63:0] rd_rdata;
  logic [1:0] wr_req, wr_gnt;
  logic [9:0] wr_addr;
  logic [31:0] wr_data;
  logic [15:0] din, dout1, dout2, perf_rd_cnt, perf_stall_cnt;
  logic [4:0] wad1, rad1, rad2;
  logic wen1, ren1, ren2, collision, flush, flush_done, err_collision;
  int checks = 0, failures = 0;
`ifdef RFARB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  regfile_port_arbiter dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_addr(rd_addr), .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_addr(wr_addr), .wr_data(wr_data),
    .din(din), .wad1(wad1), .wen1(wen1), .rad1(rad1), .ren1(ren1), .rad2(rad2), .ren2(ren2),
    .dout1(dout1), .dout2(dout2), .collision(collision),
    .flush(flush), .flush_done(flush_done), .err_collision(err_collision),
    .perf_rd_cnt(perf_rd_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  // regfile environment: one-cycle read latency, write visible from the next cycle
  logic [15:0] rf [32];
  always @(posedge clk) begin
    if (ren1) dout1 <= rf[rad1];
    if (ren2) dout2 <= rf[rad2];
    if (wen1) rf[wad1] = din;
  end

  logic [15:0] m_mem [32];
  int m_rd_ptr, m_wr_ptr, m_mode, m_rd_cnt, m_stall_cnt;
  bit m_err;
  logic [3:0] m_rv;
  logic [63:0] m_rdata;
  logic [3:0] e_rd_gnt;
  logic [1:0] e_wr_gnt;
  logic e_wen, e_ren1, e_ren2, e_stall;
  logic [4:0] e_wad, e_rad1, e_rad2;
  logic [15:0] e_din;
  int e_win[2];
  int e_nwin, e_wi;

  function automatic void model_reset();
    m_rd_ptr = 0; m_wr_ptr = 0; m_mode = 0; m_err = 0;
    m_rv = '0; m_rdata = '0; m_rd_cnt = 0; m_stall_cnt = 0;
  endfunction

  function automatic void model_eval();
    bit act = (m_mode == 0) && !flush;
    int i;
    logic [4:0] a;
    e_rd_gnt = '0; e_wr_gnt = '0; e_wen = 0; e_wad = '0; e_din = '0;
    e_ren1 = 0; e_ren2 = 0; e_rad1 = '0; e_rad2 = '0; e_stall = 0; e_nwin = 0; e_wi = -1;
    if (act) for (int k = 0; k < 2; k++) begin
      i = (m_wr_ptr + k) % 2;
      if (e_wi < 0 && wr_req[i]) e_wi = i;
    end
    if (e_wi >= 0) begin
      e_wen = 1; e_wr_gnt[e_wi] = 1; e_wad = wr_addr[5*e_wi +: 5]; e_din = wr_data[16*e_wi +: 16];
    end
    if (act) for (int k = 0; k < 4; k++) begin
      i = (m_rd_ptr + k) % 4;
      a = rd_addr[5*i +: 5];
      if (rd_req[i]) begin
        if (e_wen && a == e_wad) e_stall = 1;
        else if (e_nwin < 2) begin e_win[e_nwin] = i; e_nwin++; e_rd_gnt[i] = 1; end
      end
    end
    if (e_nwin > 0) begin e_ren1 = 1; e_rad1 = rd_addr[5*e_win[0] +: 5]; end
    if (e_nwin > 1) begin e_ren2 = 1; e_rad2 = rd_addr[5*e_win[1] +: 5]; end
  endfunction

  function automatic void model_commit();
    logic [3:0] nrv = '0;
    logic [63:0] nrd = '0;
    for (int k = 0; k < e_nwin; k++) begin
      nrv[e_win[k]] = 1'b1;
      nrd[16*e_win[k] +: 16] = m_mem[rd_addr[5*e_win[k] +: 5]];
    end
    if (e_wen) begin m_mem[e_wad] = e_din; m_wr_ptr = (e_wi + 1) % 2; end
    if (e_nwin > 0) m_rd_ptr = (e_win[e_nwin-1] + 1) % 4;
    if (m_mode == 0 && flush) m_mode = 1;
    else if (m_mode == 1 && m_rv == 0) m_mode = 2;
    else if (m_mode == 2 && !flush) m_mode = 0;
    m_err = m_err | collision;
    m_rd_cnt = (m_rd_cnt + e_nwin > 65535) ? 65535 : m_rd_cnt + e_nwin;
    m_stall_cnt = (m_stall_cnt + int'(e_stall) > 65535) ? 65535 : m_stall_cnt + int'(e_stall);
    m_rv = nrv;
    m_rdata = nrd;
  endfunction

  task automatic settle(); @(negedge clk); model_eval(); endtask
  task automatic tick(); model_commit(); @(posedge clk); #1; endtask

  task automatic do_reset();
    resetn = 0; rd_req = '0; rd_addr = '0; wr_req = '0; wr_addr = '0; wr_data = '0;
    flush = 0; collision = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1;
  endtask

  task automatic test_reset();
    resetn = 0; rd_req = '0; rd_addr = '0; wr_req = '0; wr_addr = '0; wr_data = '0;
    flush = 0; collision = 0;
    #2;
    checks++;
    if ({rd_rvalid, flush_done, err_collision} !== 6'b0) begin
      failures++; $display("FAIL reset_status got=%b exp=000000", {rd_rvalid, flush_done, err_collision});
    end
    checks++;
    if ({perf_rd_cnt, perf_stall_cnt} !== 32'h0) begin
      failures++; $display("FAIL reset_perf got=%h exp=0", {perf_rd_cnt, perf_stall_cnt});
    end
    do_reset();
    settle();
    checks++;
    if ({wen1, ren1, ren2, rd_gnt, wr_gnt} !== 9'b0) begin
      failures++; $display("FAIL idle_enables got=%b exp=0", {wen1, ren1, ren2, rd_gnt, wr_gnt});
    end
    checks++;
    if ({wad1, din, rad1, rad2, rd_rdata} !== 95'b0) begin
      failures++; $display("FAIL idle_buses got=%h exp=0", {wad1, din, rad1, rad2, rd_rdata});
    end
    tick();
  endtask

  task automatic test_write_then_read();
    do_reset();
    wr_req = 2'b01; wr_addr[4:0] = 5'd3; wr_data[15:0] = 16'd30;
    settle();
    checks++;
    if ({wen1, wad1, din, wr_gnt} !== {1'b1, 5'd3, 16'd30, 2'b01}) begin
      failures++; $display("FAIL wtr_write got=%b/%0d/%0d/%b exp=1/3/30/01", wen1, wad1, din, wr_gnt);
    end
    tick();
    wr_req = '0; rd_req = 4'b0100; rd_addr[14:10] = 5'd3;
    settle();
    checks++;
    if ({rd_gnt, ren1, rad1, ren2} !== {4'b0100, 1'b1, 5'd3, 1'b0}) begin
      failures++; $display("FAIL wtr_grant got=%b/%b/%0d/%b exp=0100/1/3/0", rd_gnt, ren1, rad1, ren2);
    end
    tick();
    rd_req = '0;
    settle();
    checks++;
    if (rd_rvalid !== 4'b0100 || rd_rdata !== {16'd0, 16'd30, 32'd0}) begin
      failures++; $display("FAIL wtr_resp got=%b/%h exp=0100/%h", rd_rvalid, rd_rdata, {16'd0, 16'd30, 32'd0});
    end
    tick();
  endtask

  task automatic test_all_readers();
    do_reset();
    rd_req = 4'b1111; rd_addr = {5'd13, 5'd12, 5'd11, 5'd10};
    settle();
    checks++;
    if ({rd_gnt, rad1, rad2} !== {4'b0011, 5'd10, 5'd11}) begin
      failures++; $display("FAIL all_c0 got=%b/%0d/%0d exp=0011/10/11", rd_gnt, rad1, rad2);
    end
    tick();
    rd_req = rd_req & ~e_rd_gnt;
    settle();
    checks++;
    if ({rd_gnt, rad1, rad2, rd_rvalid} !== {4'b1100, 5'd12, 5'd13, 4'b0011}) begin
      failures++; $display("FAIL all_c1 got=%b/%0d/%0d/%b exp=1100/12/13/0011", rd_gnt, rad1, rad2, rd_rvalid);
    end
    checks++;
    if (rd_rdata !== {32'd0, m_mem[11], m_mem[10]}) begin
      failures++; $display("FAIL all_c1_data got=%h exp=%h", rd_rdata, {32'd0, m_mem[11], m_mem[10]});
    end
    tick();
    rd_req = '0;
    settle();
    checks++;
    if (rd_rvalid !== 4'b1100 || rd_rdata !== {m_mem[13], m_mem[12], 32'd0}) begin
      failures++; $display("FAIL all_c2 got=%b/%h exp=1100/%h", rd_rvalid, rd_rdata, {m_mem[13], m_mem[12], 32'd0});
    end
    tick();
  endtask

  task automatic test_hazard();
    do_reset();
    wr_req = 2'b01; wr_addr[4:0] = 5'd5; wr_data[15:0] = 16'h0555;
    rd_req = 4'b0001; rd_addr[4:0] = 5'd5;
    settle();
    checks++;
    if ({wen1, rd_gnt, ren1} !== {1'b1, 4'b0000, 1'b0}) begin
      failures++; $display("FAIL hazard_block got=%b/%b/%b exp=1/0000/0", wen1, rd_gnt, ren1);
    end
    tick();
    wr_req = '0;
    settle();
    checks++;
    if ({rd_gnt, ren1, rad1} !== {4'b0001, 1'b1, 5'd5}) begin
      failures++; $display("FAIL hazard_retry got=%b/%b/%0d exp=0001/1/5", rd_gnt, ren1, rad1);
    end
    tick();
    rd_req = '0;
    settle();
    checks++;
    if (rd_rvalid !== 4'b0001 || rd_rdata[15:0] !== 16'h0555) begin
      failures++; $display("FAIL hazard_data got=%b/%h exp=0001/0555", rd_rvalid, rd_rdata[15:0]);
    end
    checks++;
    if (perf_stall_cnt !== (PERF ? 16'd1 : 16'd0) || perf_rd_cnt !== (PERF ? 16'd1 : 16'd0)) begin
      failures++; $display("FAIL hazard_perf got=%0d/%0d exp=%0d/%0d", perf_stall_cnt, perf_rd_cnt, PERF, PERF);
    end
    tick();
  endtask

  task automatic test_wr_alternate();
    do_reset();
    wr_req = 2'b11; wr_addr = {5'd8, 5'd7}; wr_data = {16'hBEEF, 16'hCAFE};
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++;
      if (wr_gnt !== ((k % 2 == 0) ? 2'b01 : 2'b10) || wad1 !== ((k % 2 == 0) ? 5'd7 : 5'd8)) begin
        failures++; $display("FAIL wr_alt cycle=%0d got=%b/%0d exp=%b", k, wr_gnt, wad1, (k % 2 == 0) ? 2'b01 : 2'b10);
      end
      tick();
    end
    wr_req = '0;
  endtask

  task automatic test_flush();
    do_reset();
    rd_req = 4'b0011; rd_addr = {5'd0, 5'd22, 5'd21, 5'd20};
    settle();
    checks++;
    if (rd_gnt !== 4'b0011) begin failures++; $display("FAIL flush_pre got=%b exp=0011", rd_gnt); end
    tick();
    rd_req = 4'b0100; flush = 1;
    settle();
    checks++;
    if (rd_gnt !== 4'b0 || rd_rvalid !== 4'b0011 || rd_rdata !== m_rdata) begin
      failures++; $display("FAIL flush_last got=%b/%b/%h exp=0000/0011/%h", rd_gnt, rd_rvalid, rd_rdata, m_rdata);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) flush = 0;
      settle();
      checks++;
      if (rd_gnt !== 4'b0 || flush_done !== (k != 0)) begin
        failures++; $display("FAIL flush_hold step=%0d got=%b/%b exp=0000/%b", k, rd_gnt, flush_done, k != 0);
      end
      tick();
    end
    settle();
    checks++;
    if (rd_gnt !== 4'b0100 || flush_done !== 1'b0) begin
      failures++; $display("FAIL flush_resume got=%b/%b exp=0100/0", rd_gnt, flush_done);
    end
    tick();
    rd_req = '0;
  endtask

  task automatic test_collision();
    do_reset();
    collision = 1;
    settle();
    tick();
    collision = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++;
      if (err_collision !== 1'b1) begin failures++; $display("FAIL err_sticky step=%0d got=%b exp=1", k, err_collision); end
      tick();
    end
    rd_req = 4'b0001; rd_addr[4:0] = 5'd9;
    settle();
    resetn = 0;
    #1;
    checks++;
    if (err_collision !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err_collision); end
    @(posedge clk); #1;
    checks++;
    if (rd_rvalid !== 4'b0) begin failures++; $display("FAIL inflight_drop got=%b exp=0000", rd_rvalid); end
    rd_req = '0;
    model_reset();
    resetn = 1;
    settle();
    checks++;
    if (rd_rvalid !== 4'b0 || err_collision !== 1'b0) begin
      failures++; $display("FAIL post_reset got=%b/%b exp=0000/0", rd_rvalid, err_collision);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (e_rd_gnt[i]) rd_req[i] = 0;
        if (!rd_req[i] && $urandom_range(2) == 0) begin rd_req[i] = 1; rd_addr[5*i +: 5] = 5'($urandom_range(7)); end
      end
      for (int j = 0; j < 2; j++) begin
        if (e_wr_gnt[j]) wr_req[j] = 0;
        if (!wr_req[j] && $urandom_range(3) == 0) begin
          wr_req[j] = 1; wr_addr[5*j +: 5] = 5'($urandom_range(7)); wr_data[16*j +: 16] = 16'($urandom);
        end
      end
      flush = flush ? ($urandom_range(3) != 0) : ($urandom_range(29) == 0);
      settle();
      checks++;
      if (rd_gnt !== e_rd_gnt || wr_gnt !== e_wr_gnt) begin
        failures++; $display("FAIL rnd_gnt cycle=%0d got=%b/%b exp=%b/%b", c, rd_gnt, wr_gnt, e_rd_gnt, e_wr_gnt);
      end
      checks++;
      if ({ren1, rad1, ren2, rad2, wen1, wad1, din} !== {e_ren1, e_rad1, e_ren2, e_rad2, e_wen, e_wad, e_din}) begin
        failures++; $display("FAIL rnd_ports cycle=%0d got=%h exp=%h", c, {ren1, rad1, ren2, rad2, wen1, wad1, din},
                             {e_ren1, e_rad1, e_ren2, e_rad2, e_wen, e_wad, e_din});
      end
      checks++;
      if (rd_rvalid !== m_rv || rd_rdata !== m_rdata) begin
        failures++; $display("FAIL rnd_resp cycle=%0d got=%b/%h exp=%b/%h", c, rd_rvalid, rd_rdata, m_rv, m_rdata);
      end
      checks++;
      if (flush_done !== (m_mode == 2)) begin
        failures++; $display("FAIL rnd_flush_done cycle=%0d got=%b exp=%b", c, flush_done, m_mode == 2);
      end
      checks++;
      if (perf_rd_cnt !== (PERF ? 16'(m_rd_cnt) : 16'd0) || perf_stall_cnt !== (PERF ? 16'(m_stall_cnt) : 16'd0)) begin
        failures++; $display("FAIL rnd_perf cycle=%0d got=%0d/%0d exp=%0d/%0d", c, perf_rd_cnt, perf_stall_cnt,
                             PERF ? m_rd_cnt : 0, PERF ? m_stall_cnt : 0);
      end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf[i] = 16'hA000 + 16'(i * 3);
      m_mem[i] = 16'hA000 + 16'(i * 3);
    end
    model_reset();
    e_rd_gnt = '0;
    e_wr_gnt = '0;
    test_reset();
    test_write_then_read();
    test_all_readers();
    test_hazard();
    test_wr_alternate();
    test_flush();
    test_collision();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_port_arbiter.md
REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning the register word width.
REQ-002 The block SHALL have parameter N_RD, default 4, meaning the number of read requesters.
REQ-003 The block SHALL have parameter N_WR, default 2, meaning the number of write requesters; addresses are fixed at 5 bits (32 entries).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- rd_req / rd_gnt  in / out  N_RD  read request / grant per requester.
- rd_addr  in  5*N_RD  packed read addresses.
- rd_rvalid  out  N_RD  read-response strobe.
- rd_rdata  out  DATA_WIDTH*N_RD  packed read data.
- wr_req / wr_gnt  in / out  N_WR  write request / grant.
- wr_addr / wr_data  in  5*N_WR / DATA_WIDTH*N_WR  packed write address and data.
- din, wad1, wen1  out  DATA_WIDTH, 5, 1  regfile write port.
- rad1, ren1, rad2, ren2  out  5, 1, 5, 1  regfile read ports.
- dout1, dout2, collision  in  DATA_WIDTH, DATA_WIDTH, 1  regfile outputs.
- flush / flush_done  in / out  1  drain request / drain complete.
- err_collision  out  1  sticky collision error.
- perf_rd_cnt, perf_stall_cnt  out  16 each  performance counters.

Function
REQ-005 The regfile SHALL be treated as returning dout1/dout2 one cycle after ren1/ren2 are sampled high.
REQ-006 Grants and all regfile port drives SHALL be combinational in the request cycle; a transfer completes at the clock edge where req & gnt; requesters hold req and address until granted.
REQ-007 Write port arbitration SHALL be round-robin, at most one grant per cycle; wr_ptr advances to one past the granted index after each grant.
REQ-008 Read arbitration SHALL grant up to two requesters per cycle, scanning round-robin from rd_ptr; the first winner drives port 1 and the second drives port 2; rd_ptr advances to one past the last granted index.
REQ-009 A read whose address equals the write address granted in the same cycle SHALL NOT be granted (the write wins); the read is retried next cycle and returns the new data.
REQ-010 The owner index and valid flag for each port SHALL be registered; in cycle N+1, rd_rvalid[owner] SHALL be high with rd_rdata slice = dout of that port, and all other slices SHALL be 0.
REQ-011 The state machine SHALL have states RUN, DRAIN, DONE:
- RUN -> DRAIN on flush=1; no grants are issued in DRAIN or DONE.
- DRAIN -> DONE once no response is outstanding (at most one cycle).
- DONE asserts flush_done; DONE -> RUN when flush=0.
REQ-012 A collision input high SHALL set err_collision, which stays high until reset.
REQ-013 With no requests, ren1, ren2 and wen1 SHALL be 0 and the address and data outputs SHALL be 0.

Reset
REQ-014 On resetn low, the block SHALL asynchronously clear the following: state=RUN, rd_ptr=0, wr_ptr=0, owner valids=0, rd_rvalid=0, err_collision=0, flush_done=0, counters=0.
REQ-015 Responses in flight at reset SHALL be discarded and never presented.

Configuration
REQ-016 With RFARB_PERF_CNT_EN defined, perf_rd_cnt SHALL count granted reads and perf_stall_cnt SHALL count cycles with at least one hazard-blocked read; both SHALL be 16-bit and saturate at 0xFFFF.
REQ-017 Without RFARB_PERF_CNT_EN, both counter outputs SHALL be tied to 0 and no counter flops SHALL exist.

Verification
REQ-018 The bench SHALL cover the following scenarios:
- Write req0 addr 3 data 30, then read req2 addr 3 -> wad1=3 din=30 wen1=1; next cycle rd_gnt[2]=1, ren1=1; one cycle later rd_rvalid[2]=1, rdata=30.
- All four readers request at reset -> cycle 0 grants 0,1 and cycle 1 grants 2,3; rvalid follows each grant by one cycle.
- Write addr 5 and read addr 5 in the same cycle -> read stalled one cycle, then returns new data; perf_stall_cnt=1 when the macro is on.
- Both writers request continuously -> grants alternate 0,1,0,1.
- flush asserted with reads in flight -> last rvalid delivered, flush_done=1, no grants until flush=0.
- Force collision=1 for one cycle -> err_collision stays 1 until resetn pulse.
